// File: rtl/riscv_pkg.sv
// Shared core types: XLEN plus the predictor update scheduler's state and entry types.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StFlush
  } pred_sched_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc_branch;
    logic [XLEN-1:0] pc_target;
    logic            mispred;
  } pred_upd_t;

endpackage

// File: rtl/pred_upd_fifo.sv
// Small power-of-two FIFO of resolved-branch updates with a synchronous clear.
module pred_upd_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  pred_upd_t              data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output pred_upd_t              head_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  pred_upd_t           mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     count_q;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Payload storage needs no reset; the empty flag gates its use.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i) begin
        count_q <= count_q + 1'b1;
      end else if (pop_i && !push_i) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pred_upd_sched.sv
// Branch predictor update scheduler: buffers resolved branches, drains them one per cycle,
// and walks the table on flush. Optional counters under PRED_SCHED_STATS_EN.
module pred_upd_sched
  import riscv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRED_SIZE  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bu_valid_i,
  input  logic [XLEN-1:0]              bu_pc_branch_i,
  input  logic [XLEN-1:0]              bu_pc_target_i,
  input  logic                         bu_mispred_i,
  output logic                         bu_ready_o,
  input  logic                         pred_stall_i,
  output logic                         pred_en_o,
  output logic [XLEN-1:0]              pred_pc_branch_o,
  output logic [XLEN-1:0]              pred_pc_target_o,
  output logic                         pred_success_o,
  output logic                         pred_failed_o,
  input  logic                         flush_req_i,
  output logic                         pred_inv_o,
  output logic [$clog2(PRED_SIZE)-1:0] pred_inv_idx_o,
  output logic                         flush_done_o
`ifdef PRED_SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_upd_o,
  output logic [31:0]                  stat_bp_o
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IdxW = $clog2(PRED_SIZE);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PRED_SIZE - 1);

  pred_sched_state_t state_q;
  logic [IdxW-1:0]   idx_q;
  logic              done_q;
  logic [XLEN-1:0]   hold_branch_q;
  logic [XLEN-1:0]   hold_target_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;
  pred_upd_t         fifo_head;
  pred_upd_t         bu_entry;
  logic              push;
  logic              pop;
  logic              flush_start;

  assign flush_start = flush_req_i && (state_q != StFlush);
  assign bu_ready_o  = !fifo_full && (state_q != StFlush) && !flush_req_i;
  assign push        = bu_valid_i && bu_ready_o;
  assign pop         = (state_q == StDrain) && !pred_stall_i && !flush_req_i;

  assign bu_entry = '{pc_branch: bu_pc_branch_i, pc_target: bu_pc_target_i,
                      mispred: bu_mispred_i};

  pred_upd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (flush_start),
    .data_i  (bu_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign pred_en_o        = pop;
  assign pred_success_o   = pop && !fifo_head.mispred;
  assign pred_failed_o    = pop && fifo_head.mispred;
  assign pred_pc_branch_o = fifo_empty ? hold_branch_q : fifo_head.pc_branch;
  assign pred_pc_target_o = fifo_empty ? hold_target_q : fifo_head.pc_target;
  // The done cycle stays in FLUSH so bu_ready_o only rises after the pulse.
  assign pred_inv_o       = (state_q == StFlush) && !done_q;
  assign pred_inv_idx_o   = idx_q;
  assign flush_done_o     = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      done_q        <= 1'b0;
      hold_branch_q <= '0;
      hold_target_q <= '0;
    end else begin
      if (!fifo_empty) begin
        hold_branch_q <= fifo_head.pc_branch;
        hold_target_q <= fifo_head.pc_target;
      end
      unique case (state_q)
        StIdle: begin
          if (flush_req_i) begin
            state_q <= StFlush;
            idx_q   <= '0;
          end else if (push) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (flush_req_i) begin
            state_q <= StFlush;
            idx_q   <= '0;
          end else if (pop && !push && fifo_count == CntW'(1)) begin
            state_q <= StIdle;
          end
        end
        StFlush: begin
          if (done_q) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            idx_q   <= '0;
          end else if (idx_q == LastIdx) begin
            done_q <= 1'b1;
            idx_q  <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PRED_SCHED_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_bp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_upd_q <= '0;
      stat_bp_q  <= '0;
    end else begin
      if (pop && stat_upd_q != '1) stat_upd_q <= stat_upd_q + 1'b1;
      if (bu_valid_i && !bu_ready_o && stat_bp_q != '1) stat_bp_q <= stat_bp_q + 1'b1;
    end
  end

  assign stat_upd_o = stat_upd_q;
  assign stat_bp_o  = stat_bp_q;
`endif

endmodule

// File: tb/tb_pred_upd_sched.sv
// Scoreboard bench for pred_upd_sched: stimulus pushes model expectations, a monitor pops them.
module tb_pred_upd_sched;

  localparam int unsigned FifoDepth = 4;
  localparam int unsigned PredSize  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        bu_valid;
  logic [31:0] bu_pc_branch;
  logic [31:0] bu_pc_target;
  logic        bu_mispred;
  logic        bu_ready;
  logic        pred_stall;
  logic        pred_en;
  logic [31:0] pred_pc_branch;
  logic [31:0] pred_pc_target;
  logic        pred_success;
  logic        pred_failed;
  logic        flush_req;
  logic        pred_inv;
  logic [1:0]  pred_inv_idx;
  logic        flush_done;
`ifdef PRED_SCHED_STATS_EN
  logic [31:0] stat_upd;
  logic [31:0] stat_bp;
`endif

  pred_upd_sched #(
    .FIFO_DEPTH (FifoDepth),
    .PRED_SIZE  (PredSize)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bu_valid_i       (bu_valid),
    .bu_pc_branch_i   (bu_pc_branch),
    .bu_pc_target_i   (bu_pc_target),
    .bu_mispred_i     (bu_mispred),
    .bu_ready_o       (bu_ready),
    .pred_stall_i     (pred_stall),
    .pred_en_o        (pred_en),
    .pred_pc_branch_o (pred_pc_branch),
    .pred_pc_target_o (pred_pc_target),
    .pred_success_o   (pred_success),
    .pred_failed_o    (pred_failed),
    .flush_req_i      (flush_req),
    .pred_inv_o       (pred_inv),
    .pred_inv_idx_o   (pred_inv_idx),
    .flush_done_o     (flush_done)
`ifdef PRED_SCHED_STATS_EN
    ,
    .stat_upd_o       (stat_upd),
    .stat_bp_o        (stat_bp)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pcb;
    logic [31:0] pct;
    logic        mis;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [31:0] pcb;
    logic [31:0] pct;
    logic        mis;
  } upd_t;

  // Reference model state: queued events and flush walk position (-1 = not walking).
  ent_t mq[$];
  int   fl = -1;
  bit   armed = 0;
  bit   mon_stop = 0;

  upd_t exp_upd[$];
  int   exp_inv_cyc[$];
  int   exp_inv_idx[$];
  int   exp_done_cyc[$];
  int   exp_rdy_cyc[$];
  logic exp_rdy[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none, or missing event (cycle %0d)", name, cyc);
  endtask

  task automatic cycle(input logic rst, input logic v, input logic [31:0] pcb,
                       input logic [31:0] pct, input logic mis, input logic stall,
                       input logic freq, input bit chk_rst);
    bit   ready;
    bit   en;
    ent_t e;
    @(negedge clk);
    reset        = rst;
    bu_valid     = v;
    bu_pc_branch = pcb;
    bu_pc_target = pct;
    bu_mispred   = mis;
    pred_stall   = stall;
    flush_req    = freq;
    if (armed) begin
      ready = (mq.size() < FifoDepth) && (fl < 0) && !freq;
      en    = (fl < 0) && (mq.size() > 0) && !stall && !freq;
      exp_rdy.push_back(ready);
      exp_rdy_cyc.push_back(cyc);
      if (en) exp_upd.push_back('{cyc, mq[0].pcb, mq[0].pct, mq[0].mis});
      if (fl >= 0 && fl < PredSize) begin
        exp_inv_cyc.push_back(cyc);
        exp_inv_idx.push_back(fl);
      end
      if (fl == PredSize) exp_done_cyc.push_back(cyc);
      if (!rst) begin
        if (fl >= 0) begin
          fl = (fl == PredSize) ? -1 : fl + 1;
        end else if (freq) begin
          mq.delete();
          fl = 0;
        end else begin
          if (en) void'(mq.pop_front());
          if (v && ready) begin
            e = '{pcb, pct, mis};
            mq.push_back(e);
          end
        end
      end
    end
    if (rst) begin
      mq.delete();
      fl    = -1;
      armed = 1;
    end
    if (chk_rst) begin
      #1;
      check("rst_ready", 64'(bu_ready), 64'd1);
      check("rst_en", 64'({pred_en, pred_success, pred_failed}), 64'd0);
      check("rst_inv", 64'({pred_inv, pred_inv_idx, flush_done}), 64'd0);
      check("rst_pc", {pred_pc_branch, pred_pc_target}, 64'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops expectations whenever the DUT shows a strobe, and flags overdue ones.
  initial begin
    upd_t u;
    while (!mon_stop) begin
      @(negedge clk);
      #1;
      if (exp_rdy.size() > 0 && exp_rdy_cyc[0] == cyc) begin
        void'(exp_rdy_cyc.pop_front());
        check("bu_ready", 64'(bu_ready), 64'(exp_rdy.pop_front()));
      end
      if (pred_en) begin
        if (exp_upd.size() == 0) flag("upd_unexpected");
        else begin
          u = exp_upd.pop_front();
          check("upd_cycle", 64'(cyc), 64'(u.cyc));
          check("upd_pc", {pred_pc_branch, pred_pc_target}, {u.pcb, u.pct});
          check("upd_outcome", 64'({pred_success, pred_failed}), 64'({!u.mis, u.mis}));
        end
      end else if (exp_upd.size() > 0 && exp_upd[0].cyc <= cyc) begin
        void'(exp_upd.pop_front());
        flag("upd_missing");
      end
      if (pred_inv) begin
        if (exp_inv_cyc.size() == 0) flag("inv_unexpected");
        else begin
          check("inv_cycle", 64'(cyc), 64'(exp_inv_cyc.pop_front()));
          check("inv_idx", 64'(pred_inv_idx), 64'(exp_inv_idx.pop_front()));
        end
      end else if (exp_inv_cyc.size() > 0 && exp_inv_cyc[0] <= cyc) begin
        void'(exp_inv_cyc.pop_front());
        void'(exp_inv_idx.pop_front());
        flag("inv_missing");
      end
      if (flush_done) begin
        if (exp_done_cyc.size() == 0) flag("done_unexpected");
        else check("done_cycle", 64'(cyc), 64'(exp_done_cyc.pop_front()));
      end else if (exp_done_cyc.size() > 0 && exp_done_cyc[0] <= cyc) begin
        void'(exp_done_cyc.pop_front());
        flag("done_missing");
      end
    end
  end

  initial begin
    int n_upd;
    reset = 1'b1;
    bu_valid = 0; bu_pc_branch = 0; bu_pc_target = 0; bu_mispred = 0;
    pred_stall = 0; flush_req = 0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);

    // Single push, success update one cycle later.
    cycle(0, 1, 32'h100, 32'h200, 0, 0, 0, 0);
    idle(2);

    // Stall while filling; fifth push refused; then four back-to-back updates.
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'h1000 + i, 32'h2000 + i, i[0], 1, 0, 0);
    cycle(0, 1, 32'hdead, 32'hbeef, 0, 1, 0, 0);
    idle(5);

    // Full with simultaneous pop and valid: push refused, three remain.
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'h3000 + i, 32'h4000 + i, 1, 1, 0, 0);
    cycle(0, 1, 32'h5555, 32'h6666, 0, 0, 0, 0);
    idle(4);

    // Flush with two queued entries, valid in the request cycle, second request mid-walk.
    cycle(0, 1, 32'h7000, 32'h7100, 0, 1, 0, 0);
    cycle(0, 1, 32'h7001, 32'h7101, 1, 1, 0, 0);
    cycle(0, 1, 32'h7002, 32'h7102, 0, 0, 1, 0);
    cycle(0, 1, 32'h7003, 32'h7103, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    idle(5);

    // Reset at walk index 2 aborts without a done pulse.
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 600) == 0, ($urandom % 4) != 0, $urandom, $urandom, 1'($urandom),
            ($urandom % 4) == 0, ($urandom % 80) == 0, 0);
    end
    idle(12);

    @(negedge clk);
    #2;
    mon_stop = 1;
    n_upd = exp_upd.size() + exp_inv_cyc.size() + exp_done_cyc.size();
    check("leftover_expectations", 64'(n_upd), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/pred_upd_sched.md
# pred_upd_sched

Update scheduler for the branch predictor table. It sits between the branch unit and the predictor and buffers resolved-branch events in a small FIFO. It drains those events into the predictor update port at one per cycle, yielding to a stall input. It also sequences a full-table invalidate walk on a fence/flush request.

## Interface
Parameters:
- FIFO_DEPTH, 4, update FIFO entries; power of two, at least 2
- PRED_SIZE, 4, predictor entries walked on flush

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- bu_valid_i  in  1  branch unit has a resolved branch
- bu_pc_branch_i  in  XLEN  PC of the resolved branch
- bu_pc_target_i  in  XLEN  resolved target
- bu_mispred_i  in  1  prediction was wrong
- bu_ready_o  out  1  event accepted when bu_valid_i & bu_ready_o
- pred_stall_i  in  1  predictor port busy; no update may issue this cycle
- pred_en_o  out  1  update strobe to predictor
- pred_pc_branch_o  out  XLEN  head entry branch PC
- pred_pc_target_o  out  XLEN  head entry target
- pred_success_o  out  1  pred_en_o & ~head.mispred
- pred_failed_o  out  1  pred_en_o & head.mispred
- flush_req_i  in  1  single-cycle request to invalidate the table
- pred_inv_o  out  1  invalidate strobe for one entry
- pred_inv_idx_o  out  $clog2(PRED_SIZE)  entry being invalidated
- flush_done_o  out  1  one-cycle pulse when the walk completes

## Operation
- FSM states: IDLE, DRAIN, FLUSH.
  - IDLE: FIFO empty.
  - DRAIN: FIFO non-empty.
  - FLUSH: invalidate walk in progress.
- IDLE→DRAIN on push. DRAIN→IDLE when the last entry pops with no simultaneous push.
- IDLE/DRAIN→FLUSH on flush_req_i. Flush takes priority over any push or pop that cycle.
- bu_ready_o = ~full & (state != FLUSH) & ~flush_req_i. A push is never accepted and then discarded.
- Push and pop in the same cycle are allowed when not full. Occupancy is unchanged in that case.
- When full, no push is accepted even if a pop occurs that cycle.
- Pop occurs when state == DRAIN & ~pred_stall_i & ~flush_req_i. pred_en_o equals the pop condition.
- pred_pc_*_o show the FIFO head whenever non-empty. They hold their last value when empty; consumers qualify with pred_en_o.
- On entering FLUSH:
  - FIFO contents are discarded; pointers and count are cleared.
  - The index counter starts at 0.
- FLUSH walk:
  - Each cycle asserts pred_inv_o with pred_inv_idx_o = counter, then increments the counter.
  - pred_stall_i is ignored during the walk.
  - After index PRED_SIZE-1, flush_done_o pulses for one cycle, the FSM returns to IDLE and the counter returns to 0.
- flush_req_i while in FLUSH is ignored; the walk is not restarted.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - state IDLE, FIFO empty, counter 0
  - bu_ready_o 1, pred_en_o 0, pred_success_o 0, pred_failed_o 0
  - pred_inv_o 0, pred_inv_idx_o 0, flush_done_o 0
  - pred_pc_branch_o 0, pred_pc_target_o 0
- Reset mid-flush aborts the walk with no flush_done_o. Reset mid-drain drops all entries.
- Latency push→pred_en_o: 1 cycle minimum; there is no bypass.
- Throughput: 1 update per cycle while unstalled.
- Flush latency: the request cycle, then PRED_SIZE cycles of pred_inv_o, then flush_done_o on the following cycle. bu_ready_o rises again the cycle after flush_done_o.
- All outputs are driven from registered state plus the listed inputs. There is no combinational path bu_valid_i→pred_en_o.

## Configuration
- PRED_SCHED_STATS_EN
  - Defined: adds stat_upd_o (out, 32) counting issued updates (pred_en_o cycles).
  - Defined: adds stat_bp_o (out, 32) counting cycles with bu_valid_i & ~bu_ready_o.
  - Both counters saturate at all-ones, are cleared by reset, and are not cleared by flush.
  - Undefined: these ports and their logic are absent.

## Structure
- riscv_pkg gains:
  - pred_sched_state_t (IDLE, DRAIN, FLUSH)
  - pred_upd_t struct {pc_branch, pc_target, mispred}
- XLEN comes from riscv_pkg.
- One sub-module, pred_upd_fifo:
  - parameterised on depth, storing pred_upd_t
  - push/pop/clear inputs; full/empty/head outputs
- FSM and walk counter live in the top module.

## Test plan
- Reset, then a single push (pc 0x100, tgt 0x200, mispred 0): pred_en_o=1 with pred_success_o=1 exactly one cycle later, and the FSM returns to IDLE.
- Hold pred_stall_i=1 and push 4 events: bu_ready_o drops after the 4th push. Release the stall: 4 updates issue on consecutive cycles in FIFO order.
- Full FIFO with a simultaneous pop and bu_valid_i: the push is refused and the count becomes 3.
- flush_req_i with 2 entries queued and PRED_SIZE=4: pred_inv_o is high for 4 cycles with idx 0,1,2,3, then flush_done_o pulses. No pred_en_o fires for the dropped entries.
- flush_req_i in the same cycle as bu_valid_i: bu_ready_o=0 and the event is not stored. A second flush_req_i mid-walk does not extend the walk.
- Assert reset at walk idx 2: the next cycle shows IDLE with all outputs at reset values and no flush_done_o pulse.
